// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state type and width default for the ALU arbiter
package alu_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h2B;
  localparam logic [7:0] OP_SUB  = 8'h2D;
  localparam logic [7:0] OP_MUL  = 8'h2A;
  localparam logic [7:0] OP_DIV  = 8'h2F;
  localparam logic [7:0] OP_AND  = 8'h26;
  localparam logic [7:0] OP_OR   = 8'h7C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [7:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with one-hot output
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // index of the requester granted most recently; starts at 1 so requester 0 wins first
  logic last;

  // contended requests go to the requester that was not served last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // remember the winner only when its request is actually accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters, one transaction at a time
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int WIDTH       = WIDTH_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [15:0]        req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_overflow,
  output logic               rsp_error,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   alu_data_a,
  output logic [WIDTH-1:0]   alu_data_b,
  output logic [7:0]         alu_operation,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_overflow,
  output logic               busy
);

  // the result is valid at the end of the ALU_LATENCY-th WAIT cycle
  localparam int            CW       = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LATENCY - 1);

  state_t           state;
  logic [CW-1:0]    lat_cnt;
  logic [1:0]       grant;
  logic             handshake;
  logic             hs_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [7:0]       sel_op;

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (handshake),
    .grant   (grant)
  );

  // ready is combinational in IDLE so a waiting request is taken in the first idle cycle
  always_comb begin
    req_ready = (state == IDLE) ? grant : 2'b00;
    handshake = |(req_valid & req_ready);
    hs_id     = req_ready[1];
    sel_a     = hs_id ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
    sel_b     = hs_id ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
    sel_op    = hs_id ? req_op[15:8] : req_op[7:0];
    busy      = (state != IDLE);
  end

  // transaction sequencing: accept, wait out the ALU latency, hold the response until taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      alu_data_a    <= '0;
      alu_data_b    <= '0;
      alu_operation <= OP_NONE;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_overflow  <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_id        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            rsp_id       <= hs_id;
            alu_data_a   <= sel_a;
            alu_data_b   <= sel_b;
            lat_cnt      <= '0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
            if (op_legal(sel_op)) begin
              alu_operation <= sel_op;
              rsp_error     <= 1'b0;
              state         <= WAIT;
            end else begin
              // illegal opcodes never reach the ALU and answer immediately
              alu_operation <= OP_NONE;
              rsp_error     <= 1'b1;
              rsp_valid     <= 1'b1;
              state         <= RESP;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rsp_data     <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid     <= 1'b0;
            alu_operation <= OP_NONE;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a combinational ALU stand-in
module tb_alu_arbiter;

  localparam int WIDTH = 8;
  localparam int LAT   = 1;

  logic               clock = 1'b0;
  logic               reset;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [15:0]        req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_overflow;
  logic               rsp_error;
  logic               rsp_id;
  logic [WIDTH-1:0]   alu_data_a;
  logic [WIDTH-1:0]   alu_data_b;
  logic [7:0]         alu_operation;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_overflow;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;
  int hid, lat, bad, leak0, cyc;
  int g_q[$];
  int t_q[$];
  int d_q[$];
  int i_q[$];
  logic mon_en = 1'b0;
  int   op_leak_cnt = 0;

  alu_arbiter #(.ALU_LATENCY(LAT), .WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_overflow  (rsp_overflow),
    .rsp_error     (rsp_error),
    .rsp_id        (rsp_id),
    .alu_data_a    (alu_data_a),
    .alu_data_b    (alu_data_b),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_overflow  (alu_overflow),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // stand-in Processing_Unit: signed overflow flags, DIV by zero gives 0xFF with overflow
  function automatic logic [8:0] pu_model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    logic [7:0]         r;
    logic               v;
    logic signed [15:0] p;
    r = 8'h00;
    v = 1'b0;
    p = '0;
    case (op)
      8'h2B: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      8'h2D: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      8'h2A: begin p = $signed(a) * $signed(b); r = p[7:0]; v = (p != {{8{r[7]}}, r}); end
      8'h2F: begin if (b == 8'h00) begin r = 8'hFF; v = 1'b1; end else r = a / b; end
      8'h26: r = a & b;
      8'h7C: r = a | b;
      default: ;
    endcase
    return {v, r};
  endfunction

  always_comb {alu_overflow, alu_result} = pu_model(alu_data_a, alu_data_b, alu_operation);

  always @(negedge clock) if (mon_en && alu_operation != 8'h00) op_leak_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic present(input int id, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_op[id*8 +: 8]        = op;
    req_valid[id]            = 1'b1;
  endtask

  task automatic handshake(input string tag, output int hid_o);
    int n;
    n = 0;
    hid_o = -1;
    #1;
    while (!(|(req_valid & req_ready)) && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (|(req_valid & req_ready)) hid_o = req_ready[1] ? 1 : 0;
    check({tag, "_handshake"}, (hid_o >= 0), 1);
    if (hid_o >= 0) begin
      @(posedge clock);
      @(negedge clock);
      req_valid[hid_o] = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int edges);
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(negedge clock);
      edges++;
    end
  endtask

  task automatic accept;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] op, input logic [7:0] exp_d, input logic exp_v,
                     input logic exp_e, input int exp_lat);
    int h, l;
    present(id, a, b, op);
    handshake(tag, h);
    check({tag, "_grant"}, h, id);
    wait_rsp(l);
    check({tag, "_latency"}, l, exp_lat);
    check({tag, "_data"}, rsp_data, exp_d);
    check({tag, "_overflow"}, rsp_overflow, exp_v);
    check({tag, "_error"}, rsp_error, exp_e);
    check({tag, "_rsp_id"}, rsp_id, id);
    accept;
    check({tag, "_rsp_valid_clear"}, rsp_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_busy", busy, 0);
    check("reset_alu_operation", alu_operation, 0);
    check("reset_alu_data_a", alu_data_a, 0);
    check("reset_alu_data_b", alu_data_b, 0);
    reset = 1'b0;
    @(negedge clock);

    // requester 0 ADD 15+10
    present(0, 8'd15, 8'd10, 8'h2B);
    handshake("add0", hid);
    check("add0_grant", hid, 0);
    check("add0_alu_operation", alu_operation, 8'h2B);
    check("add0_alu_data_a", alu_data_a, 8'd15);
    check("add0_alu_data_b", alu_data_b, 8'd10);
    check("add0_busy", busy, 1);
    check("add0_ready_in_wait", req_ready, 0);
    wait_rsp(lat);
    check("add0_latency", lat, LAT + 1);
    check("add0_data", rsp_data, 8'd25);
    check("add0_overflow", rsp_overflow, 0);
    check("add0_rsp_id", rsp_id, 0);
    check("add0_error", rsp_error, 0);
    accept;
    check("add0_rsp_valid_clear", rsp_valid, 0);
    check("add0_op_cleared", alu_operation, 8'h00);
    check("add0_idle", busy, 0);

    txn("add1", 1, 8'd120, 8'd10, 8'h2B, 8'h82, 1'b1, 1'b0, LAT + 1);
    txn("mul1", 1, 8'd10, 8'd20, 8'h2A, 8'hC8, 1'b1, 1'b0, LAT + 1);
    txn("div0", 0, 8'd7, 8'd0, 8'h2F, 8'hFF, 1'b1, 1'b0, LAT + 1);

    // illegal opcode: immediate error response, ALU opcode never driven
    leak0  = op_leak_cnt;
    mon_en = 1'b1;
    txn("ill0", 0, 8'd5, 8'd6, 8'h00, 8'h00, 1'b0, 1'b1, 1);
    mon_en = 1'b0;
    check("ill0_op_quiet", op_leak_cnt - leak0, 0);

    // response back-pressure for 5 cycles while requester 1 waits
    present(0, 8'd3, 8'd4, 8'h2B);
    handshake("hold", hid);
    present(1, 8'd9, 8'd9, 8'h7C);
    wait_rsp(lat);
    check("hold_latency", lat, LAT + 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'd7 || req_ready !== 2'b00) bad++;
      @(negedge clock);
    end
    check("hold_stable", bad, 0);
    accept;
    check("hold_release", rsp_valid, 0);
    #1;
    check("hold_pending_grant", req_ready, 2'b10);
    handshake("held1", hid);
    check("held1_grant", hid, 1);
    wait_rsp(lat);
    check("held1_data", rsp_data, 8'd9);
    accept;

    // reset in the middle of WAIT discards the transaction and restores requester-0 priority
    present(0, 8'd1, 8'd2, 8'h2B);
    handshake("rst", hid);
    check("rst_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_alu_operation", alu_operation, 0);
    check("rst_alu_data_a", alu_data_a, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_no_response", rsp_valid, 0);
    present(0, 8'd125, 8'd110, 8'h2D);
    present(1, 8'h01, 8'hFE, 8'h26);
    #1;
    check("rst_first_grant", req_ready, 2'b01);

    // both requesters continuously valid, consumer always ready
    rsp_ready = 1'b1;
    cyc = 0;
    while ((g_q.size() < 4 || d_q.size() < 4) && cyc < 60) begin
      #1;
      if (req_ready != 2'b00 && g_q.size() < 4) begin
        g_q.push_back(req_ready[1] ? 1 : 0);
        t_q.push_back(cyc);
      end
      if (rsp_valid && d_q.size() < 4) begin
        d_q.push_back(int'(rsp_data));
        i_q.push_back(rsp_id ? 1 : 0);
      end
      @(negedge clock);
      cyc++;
    end
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    check("rr_grant_count", g_q.size(), 4);
    check("rr_rsp_count", d_q.size(), 4);
    for (int i = 0; i < g_q.size(); i++) check($sformatf("rr_grant%0d", i), g_q[i], i % 2);
    for (int i = 0; i + 1 < t_q.size(); i++) check($sformatf("rr_spacing%0d", i), t_q[i+1] - t_q[i], LAT + 2);
    for (int i = 0; i < d_q.size(); i++) begin
      check($sformatf("rr_data%0d", i), d_q[i], (i % 2 == 0) ? 15 : 0);
      check($sformatf("rr_id%0d", i), i_q[i], i % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
